// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch unit
package fetch_unit_pkg;

  localparam int PC_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DISCARD
  } fetch_state_e;

  localparam logic [2:0] JMP_NONE     = 3'd0;
  localparam logic [2:0] JMP_REL      = 3'd1;
  localparam logic [2:0] JMP_ABS      = 3'd2;
  localparam logic [2:0] JMP_ABS_LINK = 3'd3;
  localparam logic [2:0] JMP_REL_LINK = 3'd4;

  localparam logic [PC_W-1:0] RESET_VECTOR = 20'h00000;
  localparam logic [5:0]      LINK_REG     = 6'd0;

  // Codes 5..7 are reserved and behave like JMP_NONE.
  function automatic logic is_redirect(input logic [2:0] code);
    return (code >= JMP_REL) && (code <= JMP_REL_LINK);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, register-file, imem and decoder signals of the fetch unit
interface fetch_unit_if;
  logic [2:0]  pcjumpenable;
  logic [8:0]  pcchange;
  logic [5:0]  pclocation;
  logic [5:0]  reg_rd;
  logic [15:0] reg_rd_out;
  logic [5:0]  reg_wr;
  logic [15:0] reg_wr_data;
  logic        reg_wr_enable;
  logic [19:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [19:0] programcounter;

  modport master (
    input  pcjumpenable, pcchange, pclocation, reg_rd_out, imem_ack, imem_data, instr_ready,
    output reg_rd, reg_wr, reg_wr_data, reg_wr_enable, imem_addr, imem_req,
           instr_out, instr_valid, programcounter
  );

  modport slave (
    output pcjumpenable, pcchange, pclocation, reg_rd_out, imem_ack, imem_data, instr_ready,
    input  reg_rd, reg_wr, reg_wr_data, reg_wr_enable, imem_addr, imem_req,
           instr_out, instr_valid, programcounter
  );
endinterface

// File: rtl/fetch_target.sv
// rtl/fetch_target.sv - redirect target and link-enable decode
module fetch_target
  import fetch_unit_pkg::*;
(
  input  logic [2:0]      code,
  input  logic [PC_W-1:0] issued_pc,
  input  logic [8:0]      pcchange,
  input  logic [15:0]     reg_rd_out,
  output logic [PC_W-1:0] target,
  output logic            link_en
);

  always_comb begin
    target  = issued_pc + {{(PC_W-9){pcchange[8]}}, pcchange};
    link_en = 1'b0;
    case (code)
      JMP_ABS:      target = {{(PC_W-16){1'b0}}, reg_rd_out};
      JMP_ABS_LINK: begin
        target  = {{(PC_W-16){1'b0}}, reg_rd_out};
        link_en = 1'b1;
      end
      JMP_REL_LINK: link_en = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with redirect, link write and discard
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] issued_q, issued_d;
  logic [PC_W-1:0] disc_addr_q, disc_addr_d;
  logic [PC_W-1:0] pcout_q, pcout_d;
  logic [15:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic [5:0]      wr_reg_q, wr_reg_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d;

  logic [PC_W-1:0] target;
  logic            link_en;
  logic            redirect;

  fetch_target u_target (
    .code       (bus.pcjumpenable),
    .issued_pc  (issued_q),
    .pcchange   (bus.pcchange),
    .reg_rd_out (bus.reg_rd_out),
    .target     (target),
    .link_en    (link_en)
  );

  assign redirect = is_redirect(bus.pcjumpenable);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    issued_d    = issued_q;
    disc_addr_d = disc_addr_q;
    pcout_d     = pcout_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;

    if (redirect) begin
      // A redirect squashes any coinciding handshake, so issued_q is left alone.
      pc_d    = target;
      valid_d = 1'b0;
      if (link_en) begin
        wr_en_d   = 1'b1;
        wr_reg_d  = LINK_REG;
        wr_data_d = issued_q[15:0] + 16'd1;
      end
      case (state_q)
        ST_FETCH: begin
          if (bus.imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            state_d     = ST_DISCARD;
            disc_addr_d = pc_q;
          end
        end
        ST_DISCARD: state_d = bus.imem_ack ? ST_FETCH : ST_DISCARD;
        default:    state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          if (bus.imem_ack) begin
            instr_d = bus.imem_data;
            pcout_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (valid_q && bus.instr_ready) begin
            issued_d = pcout_q;
            valid_d  = 1'b0;
            state_d  = ST_FETCH;
          end
        end
        ST_DISCARD: if (bus.imem_ack) state_d = ST_FETCH;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_VECTOR;
      issued_q    <= '0;
      disc_addr_q <= '0;
      pcout_q     <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      issued_q    <= issued_d;
      disc_addr_q <= disc_addr_d;
      pcout_q     <= pcout_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
    end
  end

  // DISCARD keeps presenting the abandoned address until its ack drains.
  assign bus.imem_req       = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
  assign bus.imem_addr      = (state_q == ST_DISCARD) ? disc_addr_q : pc_q;
  assign bus.reg_rd         = bus.pclocation;
  assign bus.reg_wr         = wr_reg_q;
  assign bus.reg_wr_data    = wr_data_q;
  assign bus.reg_wr_enable  = wr_en_q;
  assign bus.instr_out      = instr_q;
  assign bus.instr_valid    = valid_q;
  assign bus.programcounter = pcout_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  fetch_unit_if bus();

  fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] data);
    bus.imem_ack = 1'b1; bus.imem_data = data;
    step();
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.pcjumpenable = 3'd0; bus.pcchange = '0; bus.pclocation = '0; bus.reg_rd_out = '0;
    bus.imem_ack = 1'b0; bus.imem_data = '0; bus.instr_ready = 1'b0;
    reset = 1'b1;
    step(); step();
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.imem_req); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.reg_wr_enable !== 1'b0) begin failures++; $display("FAIL rst_wren got=%b exp=0", bus.reg_wr_enable); end
    checks++; if (bus.imem_addr !== 20'h0) begin failures++; $display("FAIL rst_addr got=%h exp=00000", bus.imem_addr); end
    checks++; if (bus.instr_out !== 16'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0000", bus.instr_out); end
    checks++; if (bus.programcounter !== 20'h0) begin failures++; $display("FAIL rst_pc got=%h exp=00000", bus.programcounter); end
    reset = 1'b0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 20'h0) begin failures++; $display("FAIL idle_to_fetch got req=%b addr=%h exp req=1 addr=00000", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 20'(k)) begin failures++; $display("FAIL seq_addr got req=%b addr=%h exp req=1 addr=%h", bus.imem_req, bus.imem_addr, 20'(k)); end
      bus.imem_ack = 1'b1; bus.imem_data = 16'(k);
      step();
      bus.imem_ack = 1'b0;
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'(k) || bus.programcounter !== 20'(k)) begin failures++; $display("FAIL seq_instr got v=%b instr=%h pc=%h exp v=1 instr=%h pc=%h", bus.instr_valid, bus.instr_out, bus.programcounter, 16'(k), 20'(k)); end
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL seq_hold_req got=%b exp=0", bus.imem_req); end
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
      checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL seq_bubble got=%b exp=0", bus.instr_valid); end
    end
  endtask

  task automatic test_relative_branch();
    issue(16'h0003); issue(16'h0004); issue(16'h0005);
    bus.imem_ack = 1'b1; bus.imem_data = 16'h0006;
    step();
    bus.imem_ack = 1'b0;
    bus.pcjumpenable = 3'd1; bus.pcchange = 9'h1FC;
    step();
    bus.pcjumpenable = 3'd0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rel_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 20'h00001) begin failures++; $display("FAIL rel_addr got req=%b addr=%h exp req=1 addr=00001", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.reg_wr_enable !== 1'b0) begin failures++; $display("FAIL rel_nolink got=%b exp=0", bus.reg_wr_enable); end
  endtask

  task automatic test_jump_link();
    for (int k = 1; k <= 16; k++) issue(16'(k));
    bus.imem_ack = 1'b1; bus.imem_data = 16'h0011;
    step();
    bus.imem_ack = 1'b0;
    bus.pcjumpenable = 3'd3; bus.pclocation = 6'd7; bus.reg_rd_out = 16'h1234;
    #1;
    checks++; if (bus.reg_rd !== 6'd7) begin failures++; $display("FAIL jal_rd got=%0d exp=7", bus.reg_rd); end
    step();
    bus.pcjumpenable = 3'd0;
    checks++; if (bus.imem_addr !== 20'h01234 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL jal_addr got req=%b addr=%h exp req=1 addr=01234", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.reg_wr_enable !== 1'b1 || bus.reg_wr !== 6'd0 || bus.reg_wr_data !== 16'h0011) begin failures++; $display("FAIL jal_link got en=%b reg=%0d data=%h exp en=1 reg=0 data=0011", bus.reg_wr_enable, bus.reg_wr, bus.reg_wr_data); end
    step();
    checks++; if (bus.reg_wr_enable !== 1'b0) begin failures++; $display("FAIL jal_link_pulse got=%b exp=0", bus.reg_wr_enable); end
  endtask

  task automatic test_ack_with_redirect();
    bus.pcjumpenable = 3'd4; bus.pcchange = 9'd3; bus.imem_ack = 1'b1; bus.imem_data = 16'hBEEF;
    step();
    bus.pcjumpenable = 3'd0; bus.imem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ackred_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.imem_addr !== 20'h00013 || bus.imem_req !== 1'b1) begin failures++; $display("FAIL ackred_addr got req=%b addr=%h exp req=1 addr=00013", bus.imem_req, bus.imem_addr); end
    checks++; if (bus.reg_wr_enable !== 1'b1 || bus.reg_wr_data !== 16'h0011) begin failures++; $display("FAIL ackred_link got en=%b data=%h exp en=1 data=0011", bus.reg_wr_enable, bus.reg_wr_data); end
  endtask

  task automatic test_discard();
    bus.pcjumpenable = 3'd2; bus.reg_rd_out = 16'h0040;
    step();
    bus.pcjumpenable = 3'd0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 20'h00013) begin failures++; $display("FAIL disc_hold_addr got req=%b addr=%h exp req=1 addr=00013", bus.imem_req, bus.imem_addr); end
    step();
    bus.pcjumpenable = 3'd1; bus.pcchange = 9'h1F0;
    step();
    bus.pcjumpenable = 3'd0;
    checks++; if (bus.imem_addr !== 20'h00013 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL disc_second got addr=%h v=%b exp addr=00013 v=0", bus.imem_addr, bus.instr_valid); end
    bus.imem_ack = 1'b1; bus.imem_data = 16'hDEAD;
    step();
    bus.imem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL disc_drop got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 20'h00000) begin failures++; $display("FAIL disc_target got req=%b addr=%h exp req=1 addr=00000", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_data = 16'h5A5A;
    step();
    bus.imem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h5A5A || bus.programcounter !== 20'h0) begin failures++; $display("FAIL disc_next got v=%b instr=%h pc=%h exp v=1 instr=5a5a pc=00000", bus.instr_valid, bus.instr_out, bus.programcounter); end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bus.pcjumpenable = 3'd1; bus.pcchange = 9'h1FF; bus.imem_ack = 1'b1; bus.imem_data = 16'h0001;
    step();
    bus.pcjumpenable = 3'd0; bus.imem_ack = 1'b0;
    checks++; if (bus.imem_addr !== 20'hFFFFF) begin failures++; $display("FAIL wrap_neg got=%h exp=fffff", bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_data = 16'h0007; bus.pcjumpenable = 3'd6;
    step();
    bus.imem_ack = 1'b0; bus.pcjumpenable = 3'd0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h0007 || bus.programcounter !== 20'hFFFFF) begin failures++; $display("FAIL wrap_code6 got v=%b instr=%h pc=%h exp v=1 instr=0007 pc=fffff", bus.instr_valid, bus.instr_out, bus.programcounter); end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    checks++; if (bus.imem_addr !== 20'h00000) begin failures++; $display("FAIL wrap_inc got=%h exp=00000", bus.imem_addr); end
  endtask

  task automatic test_squash();
    bus.imem_ack = 1'b1; bus.imem_data = 16'h0000;
    step();
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b1; bus.pcjumpenable = 3'd4; bus.pcchange = 9'd2;
    step();
    bus.instr_ready = 1'b0; bus.pcjumpenable = 3'd0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL squash_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.imem_addr !== 20'h00001) begin failures++; $display("FAIL squash_addr got=%h exp=00001", bus.imem_addr); end
    checks++; if (bus.reg_wr_enable !== 1'b1 || bus.reg_wr_data !== 16'h0000) begin failures++; $display("FAIL squash_link got en=%b data=%h exp en=1 data=0000", bus.reg_wr_enable, bus.reg_wr_data); end
    bus.pcjumpenable = 3'd1; bus.pcchange = 9'd0; bus.imem_ack = 1'b1;
    step();
    bus.pcjumpenable = 3'd0; bus.imem_ack = 1'b0;
    checks++; if (bus.imem_addr !== 20'hFFFFF) begin failures++; $display("FAIL squash_issued got=%h exp=fffff", bus.imem_addr); end
  endtask

  task automatic test_reset_in_hold();
    bus.imem_ack = 1'b1; bus.imem_data = 16'h2222;
    step();
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL rh_pre got=%b exp=1", bus.instr_valid); end
    reset = 1'b1; bus.pcjumpenable = 3'd3; bus.reg_rd_out = 16'h0055;
    step();
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.reg_wr_enable !== 1'b0) begin failures++; $display("FAIL rh_ctl got v=%b req=%b wen=%b exp 0 0 0", bus.instr_valid, bus.imem_req, bus.reg_wr_enable); end
    checks++; if (bus.instr_out !== 16'h0 || bus.programcounter !== 20'h0 || bus.imem_addr !== 20'h0) begin failures++; $display("FAIL rh_data got instr=%h pc=%h addr=%h exp all 0", bus.instr_out, bus.programcounter, bus.imem_addr); end
    checks++; if (bus.reg_wr !== 6'd0 || bus.reg_wr_data !== 16'h0) begin failures++; $display("FAIL rh_wr got reg=%0d data=%h exp 0 0000", bus.reg_wr, bus.reg_wr_data); end
    reset = 1'b0; bus.imem_ack = 1'b0; bus.pcjumpenable = 3'd0;
    step();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 20'h0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rh_refetch got req=%b addr=%h v=%b exp req=1 addr=00000 v=0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_relative_branch();
    test_jump_link();
    test_ack_with_redirect();
    test_discard();
    test_wrap();
    test_squash();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clock  input  1  single clock; all state updates on posedge clock.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 pcjumpenable  input  3  redirect code: 0 none, 1 relative, 2 absolute, 3 absolute+link, 4 relative+link, 5-7 treated as 0.
REQ-004 pcchange  input  9  signed relative offset, in instruction words.
REQ-005 pclocation  input  6  index of the register holding the absolute target.
REQ-006 reg_rd  output  6  register-file read address; combinationally equal to pclocation.
REQ-007 reg_rd_out  input  16  register-file read data; asynchronous, valid in the same cycle.
REQ-008 reg_wr, reg_wr_data, reg_wr_enable  output  6/16/1  link write port.
REQ-009 imem_addr, imem_req  output  20/1  instruction-memory request.
REQ-010 imem_ack, imem_data  input  1/16  instruction-memory response.
REQ-011 instr_out, instr_valid  output  16/1  instruction to the decoder.
REQ-012 instr_ready  input  1  decoder accepts instruction.
REQ-013 programcounter  output  20  PC of instr_out; feeds previous_programcounter downstream.

Function
REQ-014 The PC and all addresses SHALL be 20-bit word addresses wrapping modulo 2^20; sequential fetch SHALL be PC+1.
REQ-015 The FSM SHALL have states IDLE, FETCH, HOLD, DISCARD.
REQ-016 IDLE SHALL last exactly one cycle after reset, then go to FETCH.
REQ-017 In FETCH, imem_req SHALL be high with imem_addr=PC, held stable until imem_ack.
REQ-018 On imem_ack in FETCH with no redirect, the unit SHALL register instr_out=imem_data, programcounter=PC, and instr_valid=1; set PC=PC+1; and enter HOLD.
REQ-019 In HOLD, instr_valid SHALL remain high with stable data until instr_valid&&instr_ready.
REQ-020 On that handshake, issued_pc SHALL be set to programcounter and the FSM SHALL return to FETCH next cycle (one bubble per instruction).
REQ-021 A redirect is any cycle with pcjumpenable in 1..4; redirect SHALL take priority over every other event.
REQ-022 Targets: codes 1/4 -> issued_pc + sign_extend(pcchange); codes 2/3 -> zero_extend(reg_rd_out).
REQ-023 On a redirect, PC SHALL load the target and instr_valid SHALL drop the next cycle.
REQ-024 A handshake coinciding with a redirect SHALL be squashed: issued_pc is not updated.
REQ-025 A redirect in FETCH without ack, while imem_req is high, SHALL go to DISCARD.
REQ-026 DISCARD SHALL keep imem_req and the old address until imem_ack, drop the data, then go to FETCH at the new PC.
REQ-027 A redirect in FETCH in the same cycle as imem_ack SHALL drop the data and go to FETCH.
REQ-028 A redirect in HOLD or IDLE SHALL go to FETCH.
REQ-029 Codes 3/4 SHALL write reg_wr=LINK_REG, reg_wr_data=(issued_pc+1)[15:0], reg_wr_enable=1 for exactly one cycle after the redirect.
REQ-030 A second redirect arriving while in DISCARD SHALL overwrite the target; the last one wins.

Reset
REQ-031 On reset the FSM SHALL enter IDLE with PC=RESET_VECTOR and issued_pc=0.
REQ-032 On reset instr_valid, imem_req, and reg_wr_enable SHALL be 0, and instr_out, programcounter, imem_addr, reg_wr, and reg_wr_data SHALL be 0.
REQ-033 Reset SHALL win over any redirect or ack in the same cycle.
REQ-034 Any outstanding imem response SHALL be abandoned on reset, with no DISCARD.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the jump-code constants (JMP_NONE..JMP_REL_LINK), RESET_VECTOR=20'h00000, LINK_REG=6'd0, and the PC width of 20.
REQ-036 Target computation SHALL live in one combinational sub-module, fetch_target, with inputs code, issued_pc, pcchange, and reg_rd_out, and outputs target and link_en.

Verification
REQ-037 Reset, then ack every request with imem_data=addr[15:0] and instr_ready=1 -> imem_addr sequence 0,1,2; instr_out 0x0000,0x0001,0x0002.
REQ-038 Relative branch: after the instruction at PC 5 is issued, pcjumpenable=1, pcchange=9'h1FC (-4) -> next imem_addr=1; no link write.
REQ-039 Absolute jump-and-link: issued_pc=0x00010, pcjumpenable=3, pclocation=7, reg_rd_out=0x1234 -> reg_rd=7; next fetch 0x01234; one-cycle write reg_wr=0, data=0x0011.
REQ-040 Redirect during an outstanding request (imem_ack delayed 3 cycles) -> DISCARD entered; the late data is never presented; the next imem_addr is the target.
REQ-041 Redirect in the same cycle as instr_valid&&instr_ready -> transfer squashed, issued_pc unchanged, instr_valid low next cycle.
REQ-042 Reset asserted in HOLD with instr_valid=1 and an ack pending -> all outputs 0 next cycle, IDLE, then fetch at address 0.
